bcd_seq_conv: RTL and testbench



---
 rtl/bcd_seq_conv_if.sv | 25 ++
 rtl/bcd_seq_conv.sv | 107 ++++++++++
 tb/tb_bcd_seq_conv.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_seq_conv_if.sv
// Start/busy/done handshake bundle for the sequential binary-to-BCD converter.
// Handshake: the requester raises start with bin valid; the converter accepts
// only while idle (busy=0). busy stays high until the one-cycle done pulse,
// during which bcd/overflow are already valid and then held until the next done.
interface bcd_seq_conv_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow
  );
endinterface

// File: rtl/bcd_seq_conv.sv
// Sequential double-dabble converter: one operand bit per clock, MSB first.
// Result registers only change on the edge entering DONE, so bcd/overflow
// never show partial values. Bits lost off the top digit raise overflow.
module bcd_seq_conv #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic               clk,
  input  logic               rst,
  bcd_seq_conv_if.slave      bus,
  output logic [1:0]         dbg_state
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [BIN_W-1:0] sh_q, sh_nxt;
  logic [BW-1:0]    acc_q, acc_nxt, corr;
  logic             ovf_acc_q, carry_out;
  logic [CW-1:0]    cnt_q;
  logic [BW-1:0]    bcd_q;
  logic             ovf_q;
  logic             last_step;

  // Per-digit add-3 correction ahead of the shift (4-bit, no inter-digit carry).
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    assign corr[4*d +: 4] = (acc_q[4*d +: 4] >= 4'd5) ? acc_q[4*d +: 4] + 4'd3
                                                       : acc_q[4*d +: 4];
  end

  // Shift {digits, operand} left by one; the top digit's MSB falls out.
  assign carry_out          = corr[BW-1];
  assign {acc_nxt, sh_nxt}  = {corr[BW-2:0], sh_q, 1'b0};
  assign last_step          = (state == SHIFT) && (cnt_q == CW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.busy  = (state != IDLE);
    bus.done  = (state == DONE);
    dbg_state = state;
  end

  // Datapath: load on accept, correct-then-shift per bit, publish on last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q      <= '0;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sh_q      <= bus.bin;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= CW'(BIN_W);
          end
        end
        SHIFT: begin
          sh_q      <= sh_nxt;
          acc_q     <= acc_nxt;
          ovf_acc_q <= ovf_acc_q | carry_out;
          cnt_q     <= cnt_q - CW'(1);
          if (last_step) begin
            bcd_q <= acc_nxt;
            ovf_q <= ovf_acc_q | carry_out;
          end
        end
        default: ;
      endcase
    end
  end

  // Published result.
  always_comb begin
    bus.bcd      = bcd_q;
    bus.overflow = ovf_q;
  end

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Bench for bcd_seq_conv: three instances (8b/3 digits, 8b/2 digits,
// 17b/6 digits) driven through a shared index-based driver.
module tb_bcd_seq_conv;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT instances ----------------
  bcd_seq_conv_if #(.BIN_W(8),  .DIGITS(3)) bus0 ();
  bcd_seq_conv_if #(.BIN_W(8),  .DIGITS(2)) bus1 ();
  bcd_seq_conv_if #(.BIN_W(17), .DIGITS(6)) bus2 ();

  logic [1:0] dbg0, dbg1, dbg2;

  bcd_seq_conv #(.BIN_W(8),  .DIGITS(3)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0), .dbg_state(dbg0));
  bcd_seq_conv #(.BIN_W(8),  .DIGITS(2)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1));
  bcd_seq_conv #(.BIN_W(17), .DIGITS(6)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2), .dbg_state(dbg2));

  logic        start_s [3];
  logic [31:0] bin_s   [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic        ovf_s   [3];
  logic [23:0] bcd_s   [3];

  assign bus0.start = start_s[0];
  assign bus1.start = start_s[1];
  assign bus2.start = start_s[2];
  assign bus0.bin   = bin_s[0][7:0];
  assign bus1.bin   = bin_s[1][7:0];
  assign bus2.bin   = bin_s[2][16:0];
  assign busy_s[0] = bus0.busy;  assign done_s[0] = bus0.done;
  assign busy_s[1] = bus1.busy;  assign done_s[1] = bus1.done;
  assign busy_s[2] = bus2.busy;  assign done_s[2] = bus2.done;
  assign ovf_s[0]  = bus0.overflow;
  assign ovf_s[1]  = bus1.overflow;
  assign ovf_s[2]  = bus2.overflow;
  assign bcd_s[0]  = 24'(bus0.bcd);
  assign bcd_s[1]  = 24'(bus1.bcd);
  assign bcd_s[2]  = 24'(bus2.bcd);

  int bw [3] = '{8, 8, 17};
  int dg [3] = '{3, 2, 6};

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [24:0] exp_q[$];
  int last_done [3] = '{0, 0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by repeated division; overflow if anything remains.
  function automatic logic [24:0] model(input longint v, input int digits);
    logic [23:0] r = '0;
    longint t = v;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return {(t != 0), r};
  endfunction

  // ---------------- driver tasks ----------------
  // Hold start until the converter accepts (busy rises); n = edges waited.
  task automatic start_conv(input int k, input logic [31:0] v, input bit hold, output int n);
    start_s[k] = 1'b1;
    bin_s[k]   = v;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!busy_s[k] && n < 40);
    if (!busy_s[k]) check("accept_timeout", 32'(busy_s[k]), 32'd1);
    if (!hold) start_s[k] = 1'b0;
  endtask

  // Count edges from the accepting edge until done is seen.
  task automatic wait_done(input int k, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!done_s[k] && lat < 60);
    if (!done_s[k]) check("done_timeout", 32'(done_s[k]), 32'd1);
    last_done[k] = cyc;
  endtask

  // Full conversion with latency, result, and one-cycle done checks.
  task automatic run(input int k, input logic [31:0] v, input logic [24:0] exp);
    int n, lat;
    start_conv(k, v, 1'b0, n);
    wait_done(k, lat);
    check("latency", 32'(lat), 32'(bw[k]));
    check("busy_in_done", 32'(busy_s[k]), 32'd1);
    check("result", {7'd0, ovf_s[k], bcd_s[k]}, {7'd0, exp});
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done_s[k]), 32'd0);
    check("idle_after_done", 32'(busy_s[k]), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          k;
    logic [31:0] v;
    logic [24:0] exp;
  } vec_t;

  vec_t tab [9];

  initial begin
    int n, lat, prev, ndone;

    tab[0] = '{0, 32'd255,    {1'b0, 24'h000255}};
    tab[1] = '{0, 32'd0,      {1'b0, 24'h000000}};
    tab[2] = '{0, 32'd9,      {1'b0, 24'h000009}};
    tab[3] = '{0, 32'd100,    {1'b0, 24'h000100}};
    tab[4] = '{1, 32'd99,     {1'b0, 24'h000099}};
    tab[5] = '{1, 32'd100,    {1'b1, 24'h000000}};
    tab[6] = '{1, 32'd255,    {1'b1, 24'h000055}};
    tab[7] = '{2, 32'd99999,  {1'b0, 24'h099999}};
    tab[8] = '{2, 32'd131071, {1'b0, 24'h131071}};

    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      bin_s[k]   = '0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("reset_outputs", {busy_s[k], done_s[k], ovf_s[k], 5'd0, bcd_s[k]}, 32'd0);
    end

    // 255: busy one edge after start, result held afterwards.
    start_conv(0, 32'd255, 1'b0, n);
    check("busy_next_cycle", 32'(n), 32'd1);
    wait_done(0, lat);
    check("latency_255", 32'(lat), 32'd8);
    check("bcd_255", {7'd0, ovf_s[0], bcd_s[0]}, {7'd0, 1'b0, 24'h000255});
    repeat (10) @(posedge clk);
    #1 check("bcd_255_held", {7'd0, ovf_s[0], bcd_s[0]}, {7'd0, 1'b0, 24'h000255});

    // Table vectors; consecutive runs on one instance start on the first idle cycle.
    for (int i = 0; i < 9; i++) begin
      prev = last_done[tab[i].k];
      run(tab[i].k, tab[i].v, tab[i].exp);
      if (i > 0 && tab[i-1].k == tab[i].k)
        check("done_period", 32'(last_done[tab[i].k] - prev), 32'(bw[tab[i].k] + 2));
    end

    // start held high with a changing bin during busy: ignored, not queued.
    start_conv(0, 32'd42, 1'b1, n);
    bin_s[0] = 32'd77;
    wait_done(0, lat);
    check("held_latency", 32'(lat), 32'd8);
    check("held_bcd_42", {7'd0, ovf_s[0], bcd_s[0]}, {7'd0, 1'b0, 24'h000042});
    @(posedge clk); #1;
    check("held_idle_gap", 32'(busy_s[0]), 32'd0);
    @(posedge clk); #1;
    check("held_reaccept", 32'(busy_s[0]), 32'd1);
    start_s[0] = 1'b0;
    wait_done(0, lat);
    check("held_bcd_77", {7'd0, ovf_s[0], bcd_s[0]}, {7'd0, 1'b0, 24'h000077});
    @(posedge clk); #1;

    // Reset in the middle of a conversion.
    run(0, 32'd200, {1'b0, 24'h000200});
    start_conv(0, 32'd123, 1'b0, n);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset_outputs", {busy_s[0], done_s[0], ovf_s[0], 5'd0, bcd_s[0]}, 32'd0);
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_s[0]) ndone++;
    end
    check("midreset_no_done", 32'(ndone), 32'd0);
    run(0, 32'd7, {1'b0, 24'h000007});

    // Randomized values on every instance against the reference model.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 20; i++) begin
        logic [31:0] v;
        v = $urandom_range(0, (1 << bw[k]) - 1);
        exp_q.push_back(model(longint'(v), dg[k]));
        run(k, v, exp_q.pop_front());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
